// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD panel power sequencer.
package lcd_pkg;

  localparam int LCD_TCNT_W = 10;

  typedef enum logic [3:0] {
    ST_OFF,
    ST_VDD_UP,
    ST_SIG_UP_VS,
    ST_SIG_UP,
    ST_RUN,
    ST_BL_DN,
    ST_SIG_DN_VS,
    ST_SIG_DN,
    ST_OFF_HOLD
  } lcd_pwr_state_t;

  typedef struct packed {
    logic vdd;
    logic txen;
    logic bl;
  } lcd_out_t;

  // Output-stage levels {vdd, txen, bl} for each group of states.
  localparam lcd_out_t OUT_DARK = 3'b000;
  localparam lcd_out_t OUT_VDD  = 3'b100;
  localparam lcd_out_t OUT_SIG  = 3'b110;
  localparam lcd_out_t OUT_RUN  = 3'b111;

  function automatic lcd_out_t lcd_out_decode(lcd_pwr_state_t s);
    case (s)
      ST_VDD_UP, ST_SIG_UP_VS, ST_SIG_DN: return OUT_VDD;
      ST_SIG_UP, ST_BL_DN, ST_SIG_DN_VS:  return OUT_SIG;
      ST_RUN:                             return OUT_RUN;
      default:                            return OUT_DARK;
    endcase
  endfunction

endpackage

// File: rtl/lcd_tick_timer.sv
// Prescaler plus 10-bit tick counter; done marks the last cycle of a
// load_val x TICK_DIV interval (or the first cycle when load_val is 0).
module lcd_tick_timer
  import lcd_pkg::*;
#(
  parameter int TICK_DIV = 27000
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic                  clr,
  input  logic [LCD_TCNT_W-1:0] load_val,
  output logic                  done
);

  localparam int PW = 20;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  logic [PW-1:0]         presc;
  logic [LCD_TCNT_W-1:0] tcnt;
  logic                  tick;

  assign tick = (presc == PRESC_MAX);
  assign done = (load_val == '0) ||
                (tick && (tcnt == load_val - LCD_TCNT_W'(1)));

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      presc <= '0;
      tcnt  <= '0;
    end else if (clr) begin
      presc <= '0;
      tcnt  <= '0;
    end else if (tick) begin
      presc <= '0;
      if (tcnt != '1) tcnt <= tcnt + LCD_TCNT_W'(1);
    end else begin
      presc <= presc + PW'(1);
    end
  end

endmodule

// File: rtl/lcd_pwr_seq.sv
// Panel power sequencer: VDD -> video -> backlight on, reverse on power-down.
// Build option LCD_PWM_EN turns LCD_BL_EN into a BL_DUTY-driven PWM output.
module lcd_pwr_seq
  import lcd_pkg::*;
#(
  parameter int TICK_DIV  = 27000,
  parameter int T_VDD2SIG = 20,
  parameter int T_SIG2BL  = 200,
  parameter int T_BL2SIG  = 200,
  parameter int T_SIG2VDD = 20,
  parameter int T_OFF_MIN = 500,
  parameter int VS_TMO    = 100
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       PWR_REQ,
  input  logic       TX_VS,
  input  logic [7:0] BL_DUTY,
  output logic       LCD_VDD_EN,
  output logic       TX_ENABLE,
  output logic       LCD_BL_EN,
  output logic       PWR_READY,
  output logic       BUSY
);

  lcd_pwr_state_t        state, state_next;
  logic [LCD_TCNT_W-1:0] load_val;
  logic                  tmr_clr, tmr_done;
  logic                  vs_q, first_cyc, vs_rise;
  logic                  pwm_on;
  lcd_out_t              dec_next;

  assign tmr_clr  = (state_next != state);
  assign dec_next = lcd_out_decode(state_next);
  // Edges already present on the entry cycle of a *_VS state are discarded.
  assign vs_rise  = TX_VS && !vs_q && !first_cyc;

  lcd_tick_timer #(.TICK_DIV(TICK_DIV)) u_timer (
    .CLK      (CLK),
    .RESET_N  (RESET_N),
    .clr      (tmr_clr),
    .load_val (load_val),
    .done     (tmr_done)
  );

  // NOTE: every variable written in always_comb gets a default first so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    load_val = '0;
    case (state)
      ST_VDD_UP:                  load_val = LCD_TCNT_W'(T_VDD2SIG);
      ST_SIG_UP_VS, ST_SIG_DN_VS: load_val = LCD_TCNT_W'(VS_TMO);
      ST_SIG_UP:                  load_val = LCD_TCNT_W'(T_SIG2BL);
      ST_BL_DN:                   load_val = LCD_TCNT_W'(T_BL2SIG);
      ST_SIG_DN:                  load_val = LCD_TCNT_W'(T_SIG2VDD);
      ST_OFF_HOLD:                load_val = LCD_TCNT_W'(T_OFF_MIN);
      default:                    load_val = '0;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_OFF:       if (PWR_REQ) state_next = ST_VDD_UP;
      ST_VDD_UP:    if (!PWR_REQ)                 state_next = ST_SIG_DN;
                    else if (tmr_done)            state_next = ST_SIG_UP_VS;
      ST_SIG_UP_VS: if (!PWR_REQ)                 state_next = ST_SIG_DN;
                    else if (vs_rise || tmr_done) state_next = ST_SIG_UP;
      ST_SIG_UP:    if (!PWR_REQ)                 state_next = ST_BL_DN;
                    else if (tmr_done)            state_next = ST_RUN;
      ST_RUN:       if (!PWR_REQ)                 state_next = ST_BL_DN;
      ST_BL_DN:     if (tmr_done)                 state_next = ST_SIG_DN_VS;
      ST_SIG_DN_VS: if (vs_rise || tmr_done)      state_next = ST_SIG_DN;
      ST_SIG_DN:    if (tmr_done)                 state_next = ST_OFF_HOLD;
      ST_OFF_HOLD:  if (tmr_done)                 state_next = ST_OFF;
      default:                                    state_next = ST_OFF;
    endcase
  end

  // Outputs are decoded from the next state so they change on the same edge
  // as the state register.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state      <= ST_OFF;
      vs_q       <= 1'b0;
      first_cyc  <= 1'b0;
      LCD_VDD_EN <= 1'b0;
      TX_ENABLE  <= 1'b0;
      LCD_BL_EN  <= 1'b0;
      PWR_READY  <= 1'b0;
      BUSY       <= 1'b0;
    end else begin
      state      <= state_next;
      vs_q       <= TX_VS;
      first_cyc  <= tmr_clr;
      LCD_VDD_EN <= dec_next.vdd;
      TX_ENABLE  <= dec_next.txen;
      LCD_BL_EN  <= dec_next.bl & pwm_on;
      PWR_READY  <= (state_next == ST_RUN);
      BUSY       <= (state_next != ST_OFF) && (state_next != ST_RUN);
    end
  end

`ifdef LCD_PWM_EN
  logic [7:0] pwm_cnt, duty_q;

  // Duty is latched at wrap so a period never mixes two duty values.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      pwm_cnt <= '0;
      duty_q  <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 8'd1;
      if (pwm_cnt == 8'hFF) duty_q <= BL_DUTY;
    end
  end

  assign pwm_on = (pwm_cnt < duty_q);
`else
  logic unused_bl_duty;
  assign unused_bl_duty = ^BL_DUTY;
  assign pwm_on         = 1'b1;
`endif

endmodule

// File: doc/lcd_pwr_seq.md
# lcd_pwr_seq

Power-sequencing controller for the LVDS/RGB666 panel path. It drives panel VDD enable, video-enable to the LVDS serializer and backlight enable in the order the panel datasheet requires. It aligns video start and stop to a vsync edge and enforces a minimum power-off time. It sits between the system control register (`PWR_REQ`) and the panel output stage, in the `CLK` pixel-clock domain.

## Interface
- `TICK_DIV`, 27000: `CLK` cycles per delay tick (nominal 1 ms); 1..2^20.
- `T_VDD2SIG`, 20: ticks from VDD on to video enable (T1).
- `T_SIG2BL`, 200: ticks from video enable to backlight on (T2).
- `T_BL2SIG`, 200: ticks from backlight off to video disable (T3).
- `T_SIG2VDD`, 20: ticks from video disable to VDD off (T4).
- `T_OFF_MIN`, 500: minimum ticks VDD stays off before re-power (T5).
- `VS_TMO`, 100: ticks to wait for a vsync edge before proceeding anyway.
- All `T_*` parameters and `VS_TMO` are 0..1023 (10-bit counter).

Ports:
- `CLK` in 1: pixel clock; the same clock drives the serializer's parallel side.
- `RESET_N` in 1: asynchronous, active-low reset.
- `PWR_REQ` in 1: level; 1 = panel on requested.
- `TX_VS` in 1: vsync from the timing generator, synchronous to `CLK`, active high.
- `BL_DUTY` in 8: backlight duty; used only when `LCD_PWM_EN` is defined.
- `LCD_VDD_EN` out 1: panel logic supply enable.
- `TX_ENABLE` out 1: video gate to the serializer. When 0, the pixel/DE inputs are forced to 0 upstream and sync still runs.
- `LCD_BL_EN` out 1: backlight enable, or PWM output.
- `PWR_READY` out 1: 1 only in state RUN.
- `BUSY` out 1: 1 in every state except OFF and RUN.

## Operation
- All outputs are registered and reset to 0. The FSM resets to OFF.
- States and their outputs (VDD/TXEN/BL):
  - OFF 0/0/0
  - VDD_UP 1/0/0
  - SIG_UP_VS 1/0/0
  - SIG_UP 1/1/0
  - RUN 1/1/1
  - BL_DN 1/1/0
  - SIG_DN_VS 1/1/0
  - SIG_DN 1/0/0
  - OFF_HOLD 0/0/0
- Transitions:
  - OFF → VDD_UP when `PWR_REQ`=1.
  - VDD_UP → SIG_UP_VS after T1.
  - SIG_UP_VS → SIG_UP on a `TX_VS` rising edge or on VS timeout.
  - SIG_UP → RUN after T2.
  - RUN → BL_DN when `PWR_REQ`=0.
  - BL_DN → SIG_DN_VS after T3.
  - SIG_DN_VS → SIG_DN on a `TX_VS` rising edge or on timeout.
  - SIG_DN → OFF_HOLD after T4.
  - OFF_HOLD → OFF after T5.
- Abort on `PWR_REQ`=0 during power-up:
  - From VDD_UP or SIG_UP_VS → SIG_DN, so T4 is still honoured before VDD drops.
  - From SIG_UP → BL_DN.
- A `PWR_REQ`=1 seen during any down state or OFF_HOLD is ignored until OFF is reached. It is acted on from OFF if it is still high.
- Vsync edge detection: `TX_VS`=1 with the previous-cycle registered value=0. A rising edge present in the cycle of entry into a `*_VS` state is not counted; only edges after entry are.
- Delay engine:
  - Prescaler counts 0..`TICK_DIV`-1; tick = terminal count.
  - A 10-bit tick counter counts ticks.
  - Both counters clear on every state transition.
  - A timed state with value T lasts exactly T×`TICK_DIV` cycles. T=0 exits on the next cycle.
- Reset asserted mid-sequence: all outputs drop to 0 immediately (asynchronous). No T4/T5 ordering is guaranteed; board-level discharge handles this case.

## Timing
- Output change is coincident with the state register change. There is no extra pipeline delay.
- `PWR_REQ` rising to `LCD_VDD_EN`=1: 1 cycle (sampled in OFF at edge n, output high after edge n).
- `TX_VS` rising edge (sampled at edge n) to `TX_ENABLE`=1: 1 cycle.
- VS timeout fires after `VS_TMO`×`TICK_DIV` cycles in a `*_VS` state.

## Configuration
- `LCD_PWM_EN` defined:
  - `LCD_BL_EN` = enable AND PWM.
  - PWM uses an 8-bit free-running counter on `CLK`; output is 1 while counter < `BL_DUTY`.
  - `BL_DUTY` is sampled at counter wrap (value 255→0).
  - Duty 0 gives constant 0; 255 gives 255/256.
- `LCD_PWM_EN` undefined: `LCD_BL_EN` is a plain level, `BL_DUTY` is unused, and no PWM counter is built.

## Structure
- Shared package `lcd_pkg`:
  - State enum `lcd_pwr_state_t`.
  - Tick counter width constant `LCD_TCNT_W`=10.
  - Output-decode constants per state.
- One sub-module, `lcd_tick_timer`: prescaler plus tick counter, with inputs `clr`, `load_val` and output `done`. It is reused for T1–T5 and `VS_TMO`.
- The PWM generator is inline under the macro.

## Test plan
Parameters for all scenarios unless stated: `TICK_DIV`=4, T1=2, T2=3, T3=3, T4=2, T5=5, `VS_TMO`=4.
- Power-up: `PWR_REQ` 0→1 at cycle 0; `TX_VS` pulses at cycle 20.
  - VDD=1 at cycle 1.
  - SIG_UP_VS entered at 9.
  - `TX_ENABLE`=1 at 21.
  - BL=1 and `PWR_READY`=1 at 33.
- Power-down from RUN:
  - `PWR_REQ`→0 → BL=0 next cycle.
  - `TX_ENABLE` drops 1 cycle after the first VS edge that follows 12 cycles of BL_DN.
  - VDD drops 8 cycles later.
  - `BUSY` clears 20 cycles after that.
- VS absent: `TX_VS` held 0 → `TX_ENABLE` rises 16 cycles after SIG_UP_VS entry.
- Abort in VDD_UP: `PWR_REQ` 1 for 3 cycles → VDD=1 then SIG_DN. VDD=0 exactly 8 cycles after abort; `TX_ENABLE` never 1.
- Re-request during OFF_HOLD: `PWR_REQ`=1 → VDD stays 0 until T5 expires (20 cycles), then rises 2 cycles later (OFF→VDD_UP).
- Reset mid-RUN, and PWM:
  - `RESET_N` low → all outputs 0 the same cycle; FSM in OFF after release.
  - With `LCD_PWM_EN` and `BL_DUTY`=64 in RUN: `LCD_BL_EN` high 64 of every 256 cycles.
